// File: rtl/exc_defs.sv
// Exception code constants and sequencer defaults shared by the exception control files.
package exc_defs;

  localparam int          CODE_W     = 5;
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_INT    = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [4:0]  EXC_ADES   = 5'd5;
  localparam logic [4:0]  EXC_SYS    = 5'd8;
  localparam logic [4:0]  EXC_RI     = 5'd10;
  localparam logic [4:0]  EXC_OV     = 5'd12;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0]  EPC_IDX    = 5'd14;

endpackage

// File: rtl/m_exc_stage.sv
// One pipeline slot of exception code + BD flag; an already-carried code shadows the stage's own code.
// Flush/reset clear, hold freezes the slot, bubble loads an empty slot.
module m_exc_stage
  import exc_defs::*;
#(
  parameter int CODE_W = exc_defs::CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic [CODE_W-1:0] nxt_code,
  input  logic              nxt_bd,
  input  logic [CODE_W-1:0] stage_exc,
  output logic [CODE_W-1:0] merged,
  output logic              bd
);

  logic [CODE_W-1:0] code;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      code <= '0;
      bd   <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        code <= '0;
        bd   <= 1'b0;
      end else begin
        code <= nxt_code;
        bd   <= nxt_bd;
      end
    end
  end

  // the earliest-raised exception for this instruction wins
  assign merged = (code != '0) ? code : stage_exc;

endmodule

// File: rtl/m_exc_ctrl.sv
// Exception/interrupt sequencer: carries precise exception codes to M, flushes and redirects on
// cp0 requests, and sequences eret (EPC hazard stall, redirect to EPC, exlClear pulse at M).
module m_exc_ctrl
  import exc_defs::*;
#(
  parameter logic [31:0] HANDLER_PC = exc_defs::HANDLER_PC,
  parameter int          CODE_W     = exc_defs::CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [CODE_W-1:0] fExc,
  input  logic              fBD,
  input  logic [CODE_W-1:0] dExc,
  input  logic              dEret,
  input  logic [CODE_W-1:0] eExc,
  input  logic              eMtc0Epc,
  input  logic [CODE_W-1:0] mExc,
  input  logic              mMtc0Epc,
  input  logic              cp0Req,
  input  logic [31:0]       epcIn,
  output logic [CODE_W-1:0] excCodeM,
  output logic              bdM,
  output logic              exlClear,
  output logic              flush,
  output logic              redirect,
  output logic [31:0]       redirectPc,
  output logic              stallEret
);

  logic [CODE_W-1:0] d_code;
  logic [CODE_W-1:0] e_code;
  logic              d_bd;
  logic              e_bd;
  logic              hold_d;
  logic              eret_go;
  logic              eret_e;
  logic              eret_m;

  // eret must not read EPC while an mtc0 to EPC is still in flight
  assign stallEret = dEret & (eMtc0Epc | mMtc0Epc);
  assign hold_d    = stall | stallEret;
  assign eret_go   = dEret & ~stallEret;
  assign flush     = cp0Req;

  m_exc_stage #(.CODE_W(CODE_W)) u_stage_d (
    .clk       (clk),
    .reset     (reset),
    .flush     (cp0Req),
    .hold      (hold_d),
    .bubble    (1'b0),
    .nxt_code  (fExc),
    .nxt_bd    (fBD),
    .stage_exc (dExc),
    .merged    (d_code),
    .bd        (d_bd)
  );

  m_exc_stage #(.CODE_W(CODE_W)) u_stage_e (
    .clk       (clk),
    .reset     (reset),
    .flush     (cp0Req),
    .hold      (1'b0),
    .bubble    (hold_d),
    .nxt_code  (d_code),
    .nxt_bd    (d_bd),
    .stage_exc (eExc),
    .merged    (e_code),
    .bd        (e_bd)
  );

  m_exc_stage #(.CODE_W(CODE_W)) u_stage_m (
    .clk       (clk),
    .reset     (reset),
    .flush     (cp0Req),
    .hold      (1'b0),
    .bubble    (1'b0),
    .nxt_code  (e_code),
    .nxt_bd    (e_bd),
    .stage_exc (mExc),
    .merged    (excCodeM),
    .bd        (bdM)
  );

  always_ff @(posedge clk) begin
    if (reset || cp0Req) begin
      eret_e <= 1'b0;
      eret_m <= 1'b0;
    end else begin
      eret_e <= hold_d ? 1'b0 : eret_go;
      eret_m <= eret_e;
    end
  end

  assign exlClear = eret_m & ~cp0Req;

  always_comb begin
    redirect   = 1'b0;
    redirectPc = '0;
    if (cp0Req) begin
      redirect   = 1'b1;
      redirectPc = HANDLER_PC;
    end else if (eret_go) begin
      redirect   = 1'b1;
      redirectPc = epcIn;
    end
  end

endmodule

// File: tb/tb_m_exc_ctrl.sv
// Directed bench for m_exc_ctrl: expectations are queued with the cycle they are due and checked then.
module tb_m_exc_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [4:0]  fExc;
  logic        fBD;
  logic [4:0]  dExc;
  logic        dEret;
  logic [4:0]  eExc;
  logic        eMtc0Epc;
  logic [4:0]  mExc;
  logic        mMtc0Epc;
  logic        cp0Req;
  logic [31:0] epcIn;
  logic [4:0]  excCodeM;
  logic        bdM;
  logic        exlClear;
  logic        flush;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        stallEret;

  m_exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .fExc       (fExc),
    .fBD        (fBD),
    .dExc       (dExc),
    .dEret      (dEret),
    .eExc       (eExc),
    .eMtc0Epc   (eMtc0Epc),
    .mExc       (mExc),
    .mMtc0Epc   (mMtc0Epc),
    .cp0Req     (cp0Req),
    .epcIn      (epcIn),
    .excCodeM   (excCodeM),
    .bdM        (bdM),
    .exlClear   (exlClear),
    .flush      (flush),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .stallEret  (stallEret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {F_CODE, F_BD, F_EXL, F_FLUSH, F_REDIR, F_PC, F_SE} fld_e;
  typedef struct {
    int          due;
    string       tag;
    fld_e        fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   failures;

  task automatic expect_at(input int due, input string tag, input fld_e f, input logic [31:0] v);
    exp_t e;
    e.due = due;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_idle(input int due, input string tag);
    expect_at(due, {tag, "_code"},  F_CODE,  32'd0);
    expect_at(due, {tag, "_bd"},    F_BD,    32'd0);
    expect_at(due, {tag, "_exl"},   F_EXL,   32'd0);
    expect_at(due, {tag, "_flush"}, F_FLUSH, 32'd0);
    expect_at(due, {tag, "_redir"}, F_REDIR, 32'd0);
    expect_at(due, {tag, "_pc"},    F_PC,    32'd0);
    expect_at(due, {tag, "_se"},    F_SE,    32'd0);
  endtask

  function automatic logic [31:0] observe(input fld_e f);
    case (f)
      F_CODE:  return {27'd0, excCodeM};
      F_BD:    return {31'd0, bdM};
      F_EXL:   return {31'd0, exlClear};
      F_FLUSH: return {31'd0, flush};
      F_REDIR: return {31'd0, redirect};
      F_PC:    return redirectPc;
      F_SE:    return {31'd0, stallEret};
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Inputs are driven just after a negedge; outputs are sampled 1ns later, then time moves on.
  task automatic tick();
    logic [31:0] o;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        o = observe(sb[i].fld);
        checks++;
        assert (o === sb[i].val) else begin
          failures++;
          $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", sb[i].tag, o, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    checks = 0;
    failures = 0;
    reset = 1'b1; stall = 1'b0; fExc = 5'd4; fBD = 1'b0; dExc = 5'd0; dEret = 1'b0;
    eExc = 5'd0; eMtc0Epc = 1'b0; mExc = 5'd0; mMtc0Epc = 1'b0; cp0Req = 1'b0; epcIn = 32'd0;
    @(negedge clk);
    cyc = 0;

    // reset held two cycles with a code on fExc
    expect_idle(0, "rst0");
    expect_idle(1, "rst1");
    tick(); tick();
    reset = 1'b0; fExc = 5'd0;
    c = cyc;
    for (int k = 0; k < 3; k++) expect_at(c + k, "post_rst_code", F_CODE, 32'd0);
    tick(); tick(); tick();

    // F-stage AdEL reaches M after three edges; a later D code on it is ignored
    c = cyc;
    expect_at(c + 3, "earliest_code", F_CODE, 32'd4);
    expect_at(c + 3, "earliest_bd", F_BD, 32'd0);
    expect_at(c + 4, "earliest_drain", F_CODE, 32'd0);
    fExc = 5'd4; tick();
    fExc = 5'd0; dExc = 5'd10; tick();
    dExc = 5'd0; tick(); tick(); tick();

    // delay-slot RI reaches M with BD; cp0Req flushes everything in flight
    c = cyc;
    expect_at(c + 3, "ri_code", F_CODE, 32'd10);
    expect_at(c + 3, "ri_bd", F_BD, 32'd1);
    expect_at(c + 3, "req_flush", F_FLUSH, 32'd1);
    expect_at(c + 3, "req_redir", F_REDIR, 32'd1);
    expect_at(c + 3, "req_pc", F_PC, 32'h0000_4180);
    expect_at(c + 4, "flushed_code", F_CODE, 32'd0);
    expect_at(c + 4, "flushed_bd", F_BD, 32'd0);
    expect_at(c + 4, "flushed_redir", F_REDIR, 32'd0);
    expect_at(c + 4, "flushed_pc", F_PC, 32'd0);
    expect_at(c + 5, "flushed_code2", F_CODE, 32'd0);
    expect_at(c + 6, "flushed_code3", F_CODE, 32'd0);
    fBD = 1'b1; tick();
    fBD = 1'b0; dExc = 5'd10; tick();
    dExc = 5'd0; fExc = 5'd4; tick();
    fExc = 5'd0; cp0Req = 1'b1; tick();
    cp0Req = 1'b0; tick(); tick(); tick();

    // two stall cycles delay a Syscall in D by two cycles, no duplicate
    c = cyc;
    expect_at(c + 3, "stall_bubble0", F_CODE, 32'd0);
    expect_at(c + 4, "stall_bubble1", F_CODE, 32'd0);
    expect_at(c + 5, "stall_sys", F_CODE, 32'd8);
    expect_at(c + 6, "stall_nodup", F_CODE, 32'd0);
    expect_at(c + 7, "stall_nodup2", F_CODE, 32'd0);
    fExc = 5'd8; tick();
    fExc = 5'd0; stall = 1'b1; tick(); tick();
    stall = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    // eret behind mtc0 EPC in E then M, then redirect to EPC and exlClear two cycles later
    c = cyc;
    expect_at(c, "eret_se_e", F_SE, 32'd1);
    expect_at(c, "eret_noredir_e", F_REDIR, 32'd0);
    expect_at(c, "eret_nopc_e", F_PC, 32'd0);
    expect_at(c + 1, "eret_se_m", F_SE, 32'd1);
    expect_at(c + 1, "eret_noredir_m", F_REDIR, 32'd0);
    expect_at(c + 1, "eret_exl_early1", F_EXL, 32'd0);
    expect_at(c + 2, "eret_se_clear", F_SE, 32'd0);
    expect_at(c + 2, "eret_redir", F_REDIR, 32'd1);
    expect_at(c + 2, "eret_pc", F_PC, 32'h0000_3010);
    expect_at(c + 2, "eret_exl_early2", F_EXL, 32'd0);
    expect_at(c + 3, "eret_exl_early3", F_EXL, 32'd0);
    expect_at(c + 4, "eret_exl", F_EXL, 32'd1);
    expect_at(c + 5, "eret_exl_once", F_EXL, 32'd0);
    epcIn = 32'h0000_3010; dEret = 1'b1; eMtc0Epc = 1'b1; tick();
    eMtc0Epc = 1'b0; mMtc0Epc = 1'b1; tick();
    mMtc0Epc = 1'b0; tick();
    dEret = 1'b0; tick(); tick(); tick();

    // cp0Req beats eret in the same cycle and kills its exlClear
    c = cyc;
    expect_at(c, "race_pc", F_PC, 32'h0000_4180);
    expect_at(c, "race_flush", F_FLUSH, 32'd1);
    expect_at(c, "race_redir", F_REDIR, 32'd1);
    expect_at(c + 1, "race_redir_off", F_REDIR, 32'd0);
    for (int k = 1; k < 4; k++) expect_at(c + k, "race_no_exl", F_EXL, 32'd0);
    dEret = 1'b1; cp0Req = 1'b1; tick();
    dEret = 1'b0; cp0Req = 1'b0; tick(); tick(); tick();

    // reset mid-flight drops a pending code and the eret chain
    c = cyc;
    expect_at(c, "mid_redir", F_REDIR, 32'd1);
    expect_at(c, "mid_pc", F_PC, 32'h0000_3010);
    expect_idle(c + 1, "mid_rst");
    expect_at(c + 2, "mid_no_exl", F_EXL, 32'd0);
    expect_at(c + 3, "mid_no_exl2", F_EXL, 32'd0);
    for (int k = 2; k < 5; k++) expect_at(c + k, "mid_no_code", F_CODE, 32'd0);
    dEret = 1'b1; fExc = 5'd5; tick();
    dEret = 1'b0; fExc = 5'd0; reset = 1'b1; tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
